// File: rtl/hazard_scoreboard_pkg.sv
// Shared codes for the D-stage hazard unit: MDU operation classes and
// forwarding-select encodings.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        MDUK_NONE = 2'd0,
        MDUK_MULT = 2'd1,
        MDUK_DIV  = 2'd2,
        MDUK_ACC  = 2'd3
    } mduKind_e;

    localparam int FWD_RF = 0;
    localparam int FWD_E  = 1;
    localparam int FWD_M  = 2;
    localparam int FWD_W  = 3;

    // A Tuse of this value marks the operand as not read at all.
    localparam int TUSE_UNUSED = 3;

    function automatic logic mduStarts(input logic [1:0] kind);
        return (kind == MDUK_MULT) || (kind == MDUK_DIV);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage decode bundle into the hazard unit and its stall/forward results.
interface hazard_scoreboard_if #(
    parameter int NUM_STAGES = 3,
    parameter int TNEW_W     = 3
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic              d_valid;
    logic [4:0]        d_rs;
    logic [4:0]        d_rt;
    logic [TNEW_W-1:0] d_tuse_rs;
    logic [TNEW_W-1:0] d_tuse_rt;
    logic              d_wr_en;
    logic [4:0]        d_wr_addr;
    logic [TNEW_W-1:0] d_tnew;
    logic [1:0]        d_mdu_kind;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic              mdu_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
               d_wr_en, d_wr_addr, d_tnew, d_mdu_kind, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, mdu_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
               d_wr_en, d_wr_addr, d_tnew, d_mdu_kind, flush,
        output stall, fwd_rs_sel, fwd_rt_sel, mdu_busy
    );

endinterface

// File: rtl/hazard_scoreboard_mdu_busy_counter.sv
// Cycle-accurate MDU occupancy: loaded when a mult/div issues, counts down to idle.
module mdu_busy_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] kind,
    output logic       busy
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [CNT_W-1:0] countReg;
    logic [CNT_W-1:0] countNext;

    always_comb begin
        countNext = countReg;
        if (start && mduStarts(kind)) begin
            countNext = (kind == MDUK_MULT) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (countReg != '0) begin
            countNext = countReg - CNT_W'(1);
        end
    end

    // busy is registered from the next count so it rises the cycle after issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            countReg <= '0;
            busy     <= 1'b0;
        end else begin
            countReg <= countNext;
            busy     <= (countNext != '0);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight writer scoreboard beside the D stage: produces stall and per-operand
// forwarding selects from Tuse/Tnew, plus MDU-occupancy stalls.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int TNEW_W      = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave hz
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic              entryValidReg [NUM_STAGES];
    logic [4:0]        entryAddrReg  [NUM_STAGES];
    logic [TNEW_W-1:0] entryTnewReg  [NUM_STAGES];

    logic [NUM_STAGES-1:0] rsHit;
    logic [NUM_STAGES-1:0] rtHit;
    logic [NUM_STAGES-1:0] rsTake;
    logic [NUM_STAGES-1:0] rtTake;
    logic [NUM_STAGES-1:0] rsStallTerm;
    logic [NUM_STAGES-1:0] rtStallTerm;
    logic [SEL_W-1:0]      rsSelTerm [NUM_STAGES];
    logic [SEL_W-1:0]      rtSelTerm [NUM_STAGES];

    logic             mduBusy;
    logic             mduStall;
    logic             stallInt;
    logic             accept;
    logic             loadEntry0;
    logic [SEL_W-1:0] rsSel;
    logic [SEL_W-1:0] rtSel;

    genvar gi;

    // Youngest-match search: an entry wins only if no lower-index entry also hits.
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : gMatch
            localparam logic [NUM_STAGES-1:0] YOUNGER = NUM_STAGES'((1 << gi) - 1);

            assign rsHit[gi] = entryValidReg[gi] && (entryAddrReg[gi] == hz.d_rs) && (hz.d_rs != 5'd0);
            assign rtHit[gi] = entryValidReg[gi] && (entryAddrReg[gi] == hz.d_rt) && (hz.d_rt != 5'd0);

            assign rsTake[gi] = rsHit[gi] && !(|(rsHit & YOUNGER));
            assign rtTake[gi] = rtHit[gi] && !(|(rtHit & YOUNGER));

            assign rsStallTerm[gi] = rsTake[gi] && (entryTnewReg[gi] > hz.d_tuse_rs);
            assign rtStallTerm[gi] = rtTake[gi] && (entryTnewReg[gi] > hz.d_tuse_rt);

            assign rsSelTerm[gi] = (rsTake[gi] && (entryTnewReg[gi] == '0)) ? SEL_W'(gi + 1) : '0;
            assign rtSelTerm[gi] = (rtTake[gi] && (entryTnewReg[gi] == '0)) ? SEL_W'(gi + 1) : '0;
        end
    endgenerate

    // At most one term per operand is nonzero, so OR-reduction selects it.
    always_comb begin
        rsSel = '0;
        rtSel = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            rsSel = rsSel | rsSelTerm[i];
            rtSel = rtSel | rtSelTerm[i];
        end
    end

    assign mduStall   = (hz.d_mdu_kind != MDUK_NONE) && mduBusy;
    assign stallInt   = (|rsStallTerm || |rtStallTerm || mduStall) && hz.d_valid;
    assign accept     = hz.d_valid && !stallInt;
    assign loadEntry0 = accept && hz.d_wr_en && (hz.d_wr_addr != 5'd0);

    // Shift array: a stall drops a bubble into entry 0 while older entries advance.
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : gStage
            if (gi == 0) begin : gHead
                always_ff @(posedge clk) begin
                    if (reset) begin
                        entryValidReg[gi] <= 1'b0;
                        entryAddrReg[gi]  <= '0;
                        entryTnewReg[gi]  <= '0;
                    end else begin
                        entryValidReg[gi] <= loadEntry0 && !hz.flush;
                        entryAddrReg[gi]  <= hz.d_wr_addr;
                        entryTnewReg[gi]  <= hz.d_tnew;
                    end
                end
            end else begin : gBody
                always_ff @(posedge clk) begin
                    if (reset) begin
                        entryValidReg[gi] <= 1'b0;
                        entryAddrReg[gi]  <= '0;
                        entryTnewReg[gi]  <= '0;
                    end else begin
                        entryValidReg[gi] <= entryValidReg[gi-1] && !hz.flush;
                        entryAddrReg[gi]  <= entryAddrReg[gi-1];
                        entryTnewReg[gi]  <= (entryTnewReg[gi-1] == '0) ? '0
                                             : entryTnewReg[gi-1] - TNEW_W'(1);
                    end
                end
            end
        end
    endgenerate

    // The MDU operation is committed at issue, so flush does not gate start.
    mdu_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .kind  (hz.d_mdu_kind),
        .busy  (mduBusy)
    );

    assign hz.stall      = stallInt;
    assign hz.fwd_rs_sel = rsSel;
    assign hz.fwd_rt_sel = rtSel;
    assign hz.mdu_busy   = mduBusy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: 3- and 4-stage instances share stimulus
// and are checked against an issue-time reference model plus directed constants.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int TNEW_W = 3;
    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;
    localparam int MAXC   = 2000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_STAGES(3), .TNEW_W(TNEW_W)) bus3();
    hazard_scoreboard_if #(.NUM_STAGES(4), .TNEW_W(TNEW_W)) bus4();

    assign bus4.d_valid    = bus3.d_valid;
    assign bus4.d_rs       = bus3.d_rs;
    assign bus4.d_rt       = bus3.d_rt;
    assign bus4.d_tuse_rs  = bus3.d_tuse_rs;
    assign bus4.d_tuse_rt  = bus3.d_tuse_rt;
    assign bus4.d_wr_en    = bus3.d_wr_en;
    assign bus4.d_wr_addr  = bus3.d_wr_addr;
    assign bus4.d_tnew     = bus3.d_tnew;
    assign bus4.d_mdu_kind = bus3.d_mdu_kind;
    assign bus4.flush      = bus3.flush;

    hazard_scoreboard #(.NUM_STAGES(3), .TNEW_W(TNEW_W), .MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C))
        u_dut3 (.clk(clk), .reset(reset), .hz(bus3));
    hazard_scoreboard #(.NUM_STAGES(4), .TNEW_W(TNEW_W), .MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C))
        u_dut4 (.clk(clk), .reset(reset), .hz(bus4));

    typedef struct {
        int cyc;
        bit stall3; int rs3; int rt3; bit busy3;
        bit stall4; int rs4; int rt4; bit busy4;
    } exp_t;

    exp_t expQ[$];
    int   nCompared = 0;
    int   nMismatch = 0;

    // Reference model: record of what was accepted in each cycle, per instance.
    bit histValid [2][MAXC];
    int histAddr  [2][MAXC];
    int histTnew  [2][MAXC];
    int lastClear [2];
    int mduEnd    [2];
    int cyc = -1;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] want);
        nCompared++;
        if (act !== want) begin
            nMismatch++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, act, want);
        end
    endtask

    // An instruction issued `age` cycles ago sits in stage `age`, its result
    // ready in max(0, tnew - age) cycles; the most recent one wins.
    function automatic void resolve(input int m, input int ns, input int r, input int tuse,
                                    output bit st, output int sel);
        st  = 1'b0;
        sel = 0;
        if (r == 0) return;
        for (int age = 0; age < ns; age++) begin
            int k;
            k = cyc - 1 - age;
            if (k < 0 || k <= lastClear[m]) return;
            if (histValid[m][k] && histAddr[m][k] == r) begin
                int rem;
                rem = histTnew[m][k] - age;
                if (rem < 0) rem = 0;
                st  = (rem > tuse);
                sel = (rem == 0) ? age + 1 : 0;
                return;
            end
        end
    endfunction

    task automatic step(input bit v, input int rs, input int rt, input int tuseRs, input int tuseRt,
                        input bit wrEn, input int wrAddr, input int tnew, input int kind,
                        input bit fl, input bit rst);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = rst;
        bus3.d_valid     = v;
        bus3.d_rs        = 5'(rs);
        bus3.d_rt        = 5'(rt);
        bus3.d_tuse_rs   = TNEW_W'(tuseRs);
        bus3.d_tuse_rt   = TNEW_W'(tuseRt);
        bus3.d_wr_en     = wrEn;
        bus3.d_wr_addr   = 5'(wrAddr);
        bus3.d_tnew      = TNEW_W'(tnew);
        bus3.d_mdu_kind  = 2'(kind);
        bus3.flush       = fl;
        cyc++;
        e.cyc = cyc;
        for (int m = 0; m < 2; m++) begin
            bit stRs, stRt, mduSt, st, busy, acc;
            int selRs, selRt;
            resolve(m, (m == 0) ? 3 : 4, rs, tuseRs, stRs, selRs);
            resolve(m, (m == 0) ? 3 : 4, rt, tuseRt, stRt, selRt);
            busy  = (cyc <= mduEnd[m]);
            mduSt = (kind != 0) && busy;
            st    = (stRs || stRt || mduSt) && v;
            if (m == 0) begin
                e.stall3 = st; e.rs3 = selRs; e.rt3 = selRt; e.busy3 = busy;
            end else begin
                e.stall4 = st; e.rs4 = selRs; e.rt4 = selRt; e.busy4 = busy;
            end
            histValid[m][cyc] = 1'b0;
            if (rst) begin
                lastClear[m] = cyc;
                mduEnd[m]    = cyc;
            end else begin
                acc = v && !st;
                if (fl) begin
                    lastClear[m] = cyc;
                end else if (acc && wrEn && wrAddr != 0) begin
                    histValid[m][cyc] = 1'b1;
                    histAddr[m][cyc]  = wrAddr;
                    histTnew[m][cyc]  = tnew;
                end
                if (acc && kind == int'(MDUK_MULT)) mduEnd[m] = cyc + MULT_C;
                else if (acc && kind == int'(MDUK_DIV)) mduEnd[m] = cyc + DIV_C;
            end
        end
        expQ.push_back(e);
    endtask

    task automatic nop();
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic inst(input int rs, input int rt, input int tuseRs, input int tuseRt,
                        input bit wrEn, input int wrAddr, input int tnew, input int kind);
        step(1, rs, rt, tuseRs, tuseRt, wrEn, wrAddr, tnew, kind, 0, 0);
    endtask

    // Monitor: one expected record per cycle, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            $display("cyc=%0d stall=%0d/%0d rs=%0d/%0d rt=%0d/%0d busy=%0d/%0d", e.cyc,
                     bus3.stall, bus4.stall, bus3.fwd_rs_sel, bus4.fwd_rs_sel,
                     bus3.fwd_rt_sel, bus4.fwd_rt_sel, bus3.mdu_busy, bus4.mdu_busy);
            check("stall3", e.cyc, 32'(bus3.stall), 32'(e.stall3));
            check("rsSel3", e.cyc, 32'(bus3.fwd_rs_sel), e.rs3);
            check("rtSel3", e.cyc, 32'(bus3.fwd_rt_sel), e.rt3);
            check("busy3",  e.cyc, 32'(bus3.mdu_busy), 32'(e.busy3));
            check("stall4", e.cyc, 32'(bus4.stall), 32'(e.stall4));
            check("rsSel4", e.cyc, 32'(bus4.fwd_rs_sel), e.rs4);
            check("rtSel4", e.cyc, 32'(bus4.fwd_rt_sel), e.rt4);
            check("busy4",  e.cyc, 32'(bus4.mdu_busy), 32'(e.busy4));
        end
    end

    initial begin
        int kr;
        for (int m = 0; m < 2; m++) begin
            lastClear[m] = -1;
            mduEnd[m]    = -1;
        end
        reset = 1'b1;
        bus3.d_valid = 0; bus3.d_rs = 0; bus3.d_rt = 0; bus3.d_tuse_rs = 3; bus3.d_tuse_rt = 3;
        bus3.d_wr_en = 0; bus3.d_wr_addr = 0; bus3.d_tnew = 0; bus3.d_mdu_kind = 0; bus3.flush = 0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("resetBusy", cyc, 32'(bus3.mdu_busy), 0);
        check("resetRsSel", cyc, 32'(bus3.fwd_rs_sel), 0);
        check("resetRtSel", cyc, 32'(bus4.fwd_rt_sel), 0);

        // lw $1 (tnew 2) then addu $2,$1,$3 (tuse 1)
        repeat (4) nop();
        inst(0, 0, 3, 3, 1, 1, 2, 0);
        inst(1, 3, 1, 1, 1, 2, 1, 0);
        @(negedge clk); check("lwUseStall", cyc, 32'(bus3.stall), 1);
        inst(1, 3, 1, 1, 1, 2, 1, 0);
        @(negedge clk); check("lwUseGo", cyc, 32'(bus3.stall), 0);
        check("lwUseSelM", cyc, 32'(bus3.fwd_rs_sel), 0);
        inst(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("lwSelW", cyc, 32'(bus3.fwd_rs_sel), FWD_W);
        check("lwSelWStall", cyc, 32'(bus3.stall), 0);

        // addu $1 (tnew 1) then beq $1,$0 (tuse 0)
        repeat (3) nop();
        inst(0, 0, 3, 3, 1, 1, 1, 0);
        inst(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("beqStall", cyc, 32'(bus3.stall), 1);
        inst(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("beqSelM", cyc, 32'(bus3.fwd_rs_sel), FWD_M);
        check("beqGo", cyc, 32'(bus3.stall), 0);

        // div then mflo every cycle
        repeat (3) nop();
        inst(0, 0, 3, 3, 0, 0, 0, int'(MDUK_DIV));
        for (int i = 1; i <= DIV_C; i++) begin
            inst(0, 0, 3, 3, 1, 4, 1, int'(MDUK_ACC));
            @(negedge clk);
            check("divStall", cyc, 32'(bus3.stall), 1);
            check("divBusy", cyc, 32'(bus3.mdu_busy), 1);
        end
        inst(0, 0, 3, 3, 1, 4, 1, int'(MDUK_ACC));
        @(negedge clk); check("mfloGo", cyc, 32'(bus3.stall), 0);
        check("divIdle", cyc, 32'(bus3.mdu_busy), 0);

        // writer to $0 then reader of $0
        repeat (3) nop();
        inst(0, 0, 3, 3, 1, 0, 2, 0);
        inst(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("zeroStall", cyc, 32'(bus3.stall), 0);
        check("zeroSel", cyc, 32'(bus3.fwd_rs_sel), 0);

        // lw $5 in E when flush arrives
        repeat (3) nop();
        inst(0, 0, 3, 3, 1, 5, 2, 0);
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 1, 0);
        inst(5, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("flushStall", cyc, 32'(bus3.stall), 0);
        check("flushSel", cyc, 32'(bus3.fwd_rt_sel), 0);

        // two writers of $7 in flight: younger governs
        repeat (4) nop();
        inst(0, 0, 3, 3, 1, 7, 0, 0);
        nop();
        inst(0, 0, 3, 3, 1, 7, 0, 0);
        nop();
        inst(7, 0, 0, 3, 0, 0, 0, 0);
        @(negedge clk); check("youngSel4", cyc, 32'(bus4.fwd_rs_sel), FWD_M);

        // reset in the middle of a div
        nop();
        inst(0, 0, 3, 3, 0, 0, 0, int'(MDUK_DIV));
        inst(0, 0, 3, 3, 0, 0, 0, int'(MDUK_ACC));
        @(negedge clk); check("preRstBusy", cyc, 32'(bus3.mdu_busy), 1);
        step(1, 0, 0, 3, 3, 0, 0, 0, int'(MDUK_ACC), 0, 1);
        inst(0, 0, 3, 3, 0, 0, 0, int'(MDUK_ACC));
        @(negedge clk); check("rstBusy", cyc, 32'(bus3.mdu_busy), 0);
        check("rstGo", cyc, 32'(bus3.stall), 0);

        // randomized traffic over a small register set to force collisions
        for (int n = 0; n < 500; n++) begin
            bit v, wrEn, fl, rst;
            int kind;
            v    = ($urandom_range(0, 9) != 0);
            wrEn = ($urandom_range(0, 2) != 0);
            kr   = $urandom_range(0, 19);
            kind = (kr == 0) ? 1 : (kr == 1) ? 2 : (kr < 5) ? 3 : 0;
            fl   = ($urandom_range(0, 24) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            if (fl) kind = 0;
            step(v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), wrEn, $urandom_range(0, 3), $urandom_range(0, 3),
                 kind, fl, rst);
        end

        repeat (2) nop();
        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        check("queueDrained", cyc, 32'(expQ.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the pipelined MIPS core, sitting beside the D stage and fed by the per-instruction decode outputs (Tuse, Tnew, destination, MDU class). It tracks every in-flight register writer across a configurable number of post-decode stages and asserts `stall` when a D-stage source operand would be read before its producer is ready. It also keeps a cycle-accurate MDU busy counter, so mult/div latency is modelled in hardware instead of by a fixed stall rule. It reports the forwarding source for each D-stage operand.

## Interface
- `NUM_STAGES`, 3, number of tracked stages after D (index 0 = E, 1 = M, 2 = W).
- `TNEW_W`, 3, width of Tuse/Tnew fields.
- `MULT_CYCLES`, 5, MDU busy cycles for mult/multu.
- `DIV_CYCLES`, 10, MDU busy cycles for div/divu.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `d_valid`  in  1  D stage holds a real instruction.
- `d_rs`, `d_rt`  in  5  source register numbers.
- `d_tuse_rs`, `d_tuse_rt`  in  TNEW_W  cycles until use; value 3 means unused.
- `d_wr_en`  in  1  instruction writes the GPR file.
- `d_wr_addr`  in  5  destination register.
- `d_tnew`  in  TNEW_W  cycles after entering E until the result exists.
- `d_mdu_kind`  in  2  0 none, 1 mult-class, 2 div-class, 3 other MDU access (mf/mt).
- `flush`  in  1  exception/eret pipeline clear.
- `stall`  out  1  freeze PC and F/D, inject bubble into E.
- `fwd_rs_sel`, `fwd_rt_sel`  out  $clog2(NUM_STAGES+1)  0 = register file, i+1 = stage i.
- `mdu_busy`  out  1  registered; MDU counter nonzero.

## Operation
- Scoreboard: NUM_STAGES entries `{valid, addr[4:0], tnew}`.
- Entry 0 loads `{d_valid & d_wr_en & ~stall & (d_wr_addr != 0), d_wr_addr, d_tnew}`. Entry i loads entry i-1 with tnew decremented, saturating at 0.
- Match for rs: entry valid, entry.addr == d_rs, and d_rs != 0. Only the youngest matching entry (lowest index) is considered. The same rule applies to rt.
- Stall for rs: the youngest match has tnew > d_tuse_rs. `stall` = (rs_stall | rt_stall | mdu_stall) & d_valid.
- Forward: if the youngest match has tnew == 0, sel = index+1; otherwise sel = 0. With no stall, a not-ready operand is re-resolved in a later stage.
- MDU counter, width $clog2(DIV_CYCLES+1):
  - On an accepted instruction (d_valid & ~stall), kind 1 loads MULT_CYCLES and kind 2 loads DIV_CYCLES.
  - Otherwise the counter decrements when nonzero.
- mdu_stall = (d_mdu_kind != 0) & mdu_busy.
- `flush` clears all entry valids on the next edge and blocks loading of entry 0. The MDU counter is unaffected, because the operation is committed at issue.
- `reset` clears all valids and the counter, so `mdu_busy` = 0 and both fwd sels = 0.

## Timing
- `stall` and `fwd_*_sel` are combinational from the current entries and D inputs. They have no registered latency.
- `mdu_busy` goes high the cycle after a mult/div is accepted. It stays high for exactly MULT_CYCLES/DIV_CYCLES cycles.
- A stalled cycle inserts a bubble: entry 0 is invalid next cycle while older entries still advance.
- flush together with d_valid: flush wins and nothing is captured.
- reset together with flush or a start: reset wins.
- Writer to $0 is never recorded. Reader of $0 never stalls.
- Two in-flight writers to the same register: the youngest governs both stall and forwarding.

## Structure
- Constants.v gains:
  - MDU kind codes `MDUK_NONE/MULT/DIV/ACC`.
  - Forwarding select codes `FWD_RF`, `FWD_E`, `FWD_M`, `FWD_W`.
- One sub-module: `mdu_busy_counter` (parameters MULT_CYCLES, DIV_CYCLES; inputs start, kind; output busy).
- The scoreboard shift array and the youngest-match priority search are written with a generate loop over NUM_STAGES.

## Test plan
- lw $1 (tnew 2), then addu $2,$1,$3 (tuse 1) → stall high 1 cycle, then fwd_rs_sel = 3 (W). No stall in the following cycle.
- addu $1 (tnew 1), then beq $1,$0 (tuse 0) → stall 1 cycle, then fwd_rs_sel = 2 (M).
- div accepted, then mflo every cycle → mdu_busy high for 10 cycles; stall high for those 10 cycles; mflo accepted on cycle 11.
- Writer to $0, then a reader of $0 → stall 0, fwd sel 0.
- lw $5 in E, flush asserted → next cycle all entries invalid; reader of $5 does not stall; fwd sel 0.
- NUM_STAGES = 4, writes to $7 in stages 1 and 3 → sel follows stage 1 (youngest); reset mid-div drops mdu_busy on the next edge.
